// File: rtl/format9_pkg.sv
// Shared types and helpers for the format9 accumulator: constants, FSM
// state encoding, the extended-precision accumulator record and the
// alignment / packing helpers.
package format9_pkg;

  localparam int GUARD_BITS = 3;
  localparam int EXP_BIAS   = 127;

  // Significand with hidden bit plus guard bits; the adder adds one carry bit.
  localparam int MANT_W = 8 + GUARD_BITS;
  localparam int SUM_W  = MANT_W + 1;
  localparam int LZC_W  = $clog2(SUM_W + 1);

  localparam logic [15:0] QNAN    = 16'h7FC0;
  localparam logic [7:0]  EXP_INF = 8'hFF;

  // Exponents are held unbiased and signed inside the accumulator.
  localparam logic signed [9:0] BIAS_S   = 10'(EXP_BIAS);
  localparam logic signed [9:0] EXP_OVF  = 10'sd255 - BIAS_S;
  localparam logic signed [9:0] EXP_ZERO = -BIAS_S;
  localparam logic [9:0]        MANT_W10 = 10'(MANT_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    OUT   = 3'd4
  } state_t;

  typedef struct packed {
    logic                sign;
    logic signed [9:0]   exp;
    logic [MANT_W-1:0]   mant;
    logic                is_nan;
    logic                is_inf;
  } acc_t;

  localparam acc_t ACC_ZERO = '{sign: 1'b0, exp: EXP_ZERO, mant: '0,
                                is_nan: 1'b0, is_inf: 1'b0};

  // Biased 8-bit exponent field to signed unbiased exponent.
  function automatic logic signed [9:0] unbias(input logic [7:0] e);
    return $signed({2'b00, e}) - BIAS_S;
  endfunction

  // Right shift whose lost bits are ORed into the LSB (sticky).
  function automatic logic [MANT_W-1:0] shr_sticky(input logic [MANT_W-1:0] m,
                                                   input logic [9:0]        d);
    logic [MANT_W-1:0] mask;
    logic [MANT_W-1:0] r;
    if (d >= MANT_W10) begin
      r = {{(MANT_W-1){1'b0}}, |m};
    end else begin
      mask = ~({MANT_W{1'b1}} << d);
      r    = m >> d;
      r[0] = r[0] | (|(m & mask));
    end
    return r;
  endfunction

  // Round-to-nearest-even and pack into {S, E[7:0], M[6:0]}.
  function automatic logic [15:0] pack_acc(input acc_t a);
    logic              up;
    logic [8:0]        rnd;
    logic signed [9:0] be;
    logic [15:0]       r;
    up  = a.mant[GUARD_BITS-1] &
          ((|a.mant[GUARD_BITS-2:0]) | a.mant[GUARD_BITS]);
    rnd = {1'b0, a.mant[MANT_W-1:GUARD_BITS]} + {8'h00, up};
    be  = a.exp + BIAS_S + $signed({9'h000, rnd[8]});
    if (a.is_nan) begin
      r = QNAN;
    end else if (a.is_inf) begin
      r = {a.sign, EXP_INF, 7'h00};
    end else if (a.mant == '0) begin
      r = 16'h0000;
    end else if (be >= 10'sd255) begin
      r = {a.sign, EXP_INF, 7'h00};
    end else begin
      // On mantissa carry-out rnd[7:0] is zero, so the fraction is zero too.
      r = {a.sign, be[7:0], rnd[6:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/format9_lzc.sv
// Combinational leading-zero counter over the adder result magnitude.
// An all-zero input reports W.
module format9_lzc #(
  parameter int W  = 12,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_value,
  output logic [CW-1:0] o_count
);

  // Scan upward so the highest set bit decides the count.
  always_comb begin
    o_count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (i_value[i]) o_count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/format9_madd_accum.sv
// format9 vector accumulator: sums a stream of 16-bit products
// (1/8/7, bias 127) in an extended-precision accumulator and emits the
// rounded sum on the product flagged last. Each product runs through
// ALIGN, ADD and NORM, so one product is accepted every 4 cycles.
// Optional build macro FORMAT9_ACC_FLAGS_EN adds sum_flags
// {invalid, overflow, underflow}, sticky per vector.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. The producer keeps data/last stable while valid is
// high and ready is low; this block keeps sum_data stable while
// sum_valid is high and sum_ready is low, and never drops sum_valid
// before the handshake.
module format9_madd_accum
  import format9_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        prod_valid,
  output logic        prod_ready,
  input  logic [15:0] prod_data,
  input  logic        prod_last,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic [15:0] sum_data
`ifdef FORMAT9_ACC_FLAGS_EN
  ,
  output logic [2:0]  sum_flags
`endif
);

  localparam logic [LZC_W-1:0] LZ_ONE = LZC_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic                r_alive;
  logic [15:0]         r_op;
  logic                r_last;
  acc_t                r_acc;
  logic [MANT_W-1:0]   r_a_mag;
  logic [MANT_W-1:0]   r_b_mag;
  logic                r_a_sign;
  logic                r_b_sign;
  logic signed [9:0]   r_exp;
  logic [SUM_W-1:0]    r_sum;
  logic                r_sum_sign;
  logic [15:0]         r_sum_data;

  logic                w_prod_hs;
  logic                w_sum_hs;

  logic [7:0]          w_op_e;
  logic [6:0]          w_op_m;
  logic                w_op_zero;
  logic                w_op_inf;
  logic                w_op_nan;
  logic [MANT_W-1:0]   w_op_mag;
  logic signed [9:0]   w_op_exp;

  logic [MANT_W-1:0]   w_big_mag;
  logic [MANT_W-1:0]   w_small_mag;
  logic [MANT_W-1:0]   w_small_al;
  logic                w_big_sign;
  logic                w_small_sign;
  logic signed [9:0]   w_big_exp;
  logic signed [9:0]   w_small_exp;
  logic [9:0]          w_diff;
  logic                w_inf_clash;
  logic                w_res_nan;
  logic                w_res_inf;

  logic [SUM_W-1:0]    w_sum;
  logic                w_sum_sign;

  logic [LZC_W-1:0]    w_lz;
  logic [LZC_W-1:0]    w_lsh;
  logic [MANT_W-1:0]   w_nmant;
  logic signed [9:0]   w_nexp;
  logic                w_sum_zero;
  logic                w_acc_special;
  acc_t                w_norm;
  logic [15:0]         w_pack;

  assign w_prod_hs = prod_valid & prod_ready;
  assign w_sum_hs  = sum_valid & sum_ready;

  // ---------------- FSM ----------------

  // State register; r_alive holds prod_ready low until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_next;
      r_alive <= 1'b1;
    end
  end

  // Next-state: fixed ALIGN/ADD/NORM walk, OUT only after the last product.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_prod_hs) w_next = ALIGN;
      ALIGN:   w_next = ADD;
      ADD:     w_next = NORM;
      NORM:    w_next = r_last ? OUT : IDLE;
      OUT:     if (w_sum_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Stream outputs decoded from the state.
  always_comb begin
    prod_ready = r_alive & (r_state == IDLE);
    sum_valid  = (r_state == OUT);
  end

  assign sum_data = r_sum_data;

  // ---------------- ALIGN ----------------

  assign w_op_e    = r_op[14:7];
  assign w_op_m    = r_op[6:0];
  assign w_op_zero = (w_op_e == 8'h00);
  assign w_op_inf  = (w_op_e == EXP_INF) & (w_op_m == 7'h00);
  assign w_op_nan  = (w_op_e == EXP_INF) & (w_op_m != 7'h00);
  assign w_op_mag  = w_op_zero ? '0 : {1'b1, w_op_m, {GUARD_BITS{1'b0}}};
  assign w_op_exp  = w_op_zero ? EXP_ZERO : unbias(w_op_e);

  assign w_inf_clash = w_op_inf & r_acc.is_inf & (r_op[15] != r_acc.sign);
  assign w_res_nan   = r_acc.is_nan | w_op_nan | w_inf_clash;
  assign w_res_inf   = ~w_res_nan & (r_acc.is_inf | w_op_inf);

  // Order operands by exponent and shift the smaller one into place.
  always_comb begin
    if ($signed(w_op_exp) > $signed(r_acc.exp)) begin
      w_big_mag    = w_op_mag;
      w_big_sign   = r_op[15];
      w_big_exp    = w_op_exp;
      w_small_mag  = r_acc.mant;
      w_small_sign = r_acc.sign;
      w_small_exp  = r_acc.exp;
    end else begin
      w_big_mag    = r_acc.mant;
      w_big_sign   = r_acc.sign;
      w_big_exp    = r_acc.exp;
      w_small_mag  = w_op_mag;
      w_small_sign = r_op[15];
      w_small_exp  = w_op_exp;
    end
    w_diff     = w_big_exp - w_small_exp;
    w_small_al = shr_sticky(w_small_mag, w_diff);
  end

  // ---------------- ADD ----------------

  // Signed-magnitude add; the result takes the sign of the larger magnitude.
  always_comb begin
    if (r_a_sign == r_b_sign) begin
      w_sum      = {1'b0, r_a_mag} + {1'b0, r_b_mag};
      w_sum_sign = r_a_sign;
    end else if (r_a_mag >= r_b_mag) begin
      w_sum      = {1'b0, r_a_mag} - {1'b0, r_b_mag};
      w_sum_sign = r_a_sign;
    end else begin
      w_sum      = {1'b0, r_b_mag} - {1'b0, r_a_mag};
      w_sum_sign = r_b_sign;
    end
  end

  // ---------------- NORM ----------------

  format9_lzc #(
    .W  (SUM_W),
    .CW (LZC_W)
  ) u_lzc (
    .i_value (r_sum),
    .o_count (w_lz)
  );

  assign w_lsh         = w_lz - LZ_ONE;
  assign w_sum_zero    = (r_sum == '0);
  assign w_acc_special = r_acc.is_nan | r_acc.is_inf;

  // Bring the leading one to the hidden-bit position and fix the exponent.
  always_comb begin
    w_nmant = r_sum[MANT_W-1:0] << w_lsh;
    w_nexp  = r_exp - $signed({{(10-LZC_W){1'b0}}, w_lsh});
    if (r_sum[SUM_W-1]) begin
      w_nmant = {r_sum[SUM_W-1:2], |r_sum[1:0]};
      w_nexp  = r_exp + 10'sd1;
    end
  end

  // Normalised accumulator: cancellation and flush give +0, overflow gives inf.
  always_comb begin
    w_norm = r_acc;
    if (!w_acc_special) begin
      if (w_sum_zero) begin
        w_norm = ACC_ZERO;
      end else if (w_nexp >= EXP_OVF) begin
        w_norm.is_inf = 1'b1;
        w_norm.sign   = r_sum_sign;
      end else if (w_nexp <= EXP_ZERO) begin
        w_norm = ACC_ZERO;
      end else begin
        w_norm.sign = r_sum_sign;
        w_norm.exp  = w_nexp;
        w_norm.mant = w_nmant;
      end
    end
  end

  assign w_pack = pack_acc(w_norm);

  // ---------------- datapath registers ----------------

  // Operand capture, pipeline registers, accumulator and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= 16'h0000;
      r_last     <= 1'b0;
      r_acc      <= ACC_ZERO;
      r_a_mag    <= '0;
      r_b_mag    <= '0;
      r_a_sign   <= 1'b0;
      r_b_sign   <= 1'b0;
      r_exp      <= EXP_ZERO;
      r_sum      <= '0;
      r_sum_sign <= 1'b0;
      r_sum_data <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_prod_hs) begin
            r_op   <= prod_data;
            r_last <= prod_last;
          end
        end
        ALIGN: begin
          r_a_mag      <= w_big_mag;
          r_a_sign     <= w_big_sign;
          r_b_mag      <= w_small_al;
          r_b_sign     <= w_small_sign;
          r_exp        <= w_big_exp;
          r_acc.is_nan <= w_res_nan;
          r_acc.is_inf <= w_res_inf;
          if (w_res_inf && !r_acc.is_inf) r_acc.sign <= r_op[15];
        end
        ADD: begin
          r_sum      <= w_sum;
          r_sum_sign <= w_sum_sign;
        end
        NORM: begin
          r_acc <= w_norm;
          if (r_last) r_sum_data <= w_pack;
        end
        OUT: begin
          if (w_sum_hs) r_acc <= ACC_ZERO;
        end
        default: ;
      endcase
    end
  end

`ifdef FORMAT9_ACC_FLAGS_EN
  logic       w_new_invalid;
  logic       w_norm_ovf;
  logic       w_norm_unf;
  logic       w_pack_ovf;
  logic [2:0] r_flags;

  assign w_new_invalid = w_op_nan | w_inf_clash;
  assign w_norm_ovf    = ~w_acc_special & ~w_sum_zero & (w_nexp >= EXP_OVF);
  assign w_norm_unf    = ~w_acc_special & ~w_sum_zero & (w_nexp < EXP_OVF) &
                         (w_nexp <= EXP_ZERO);
  // Rounding carry into the all-ones exponent is also an arithmetic overflow.
  assign w_pack_ovf    = r_last & ~w_norm.is_inf & ~w_norm.is_nan &
                         (w_pack[14:7] == EXP_INF);

  // Sticky exception flags, cleared when the sum is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= 3'b000;
    end else begin
      case (r_state)
        ALIGN:   r_flags[2] <= r_flags[2] | w_new_invalid;
        NORM: begin
          r_flags[1] <= r_flags[1] | w_norm_ovf | w_pack_ovf;
          r_flags[0] <= r_flags[0] | w_norm_unf;
        end
        OUT:     if (w_sum_hs) r_flags <= 3'b000;
        default: ;
      endcase
    end
  end

  assign sum_flags = r_flags;
`endif

endmodule

// File: tb/tb_format9_madd_accum.sv
// Directed bench for format9_madd_accum: hand-computed vectors, a queue of
// expected sums, backpressure and mid-operation reset checks.
module tb_format9_madd_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] prod_data;
  logic        prod_last;
  logic        sum_valid;
  logic        sum_ready;
  logic [15:0] sum_data;
`ifdef FORMAT9_ACC_FLAGS_EN
  logic [2:0]  sum_flags;
  logic [2:0]  seen_flags;
`endif

  int n_tests     = 0;
  int n_fail      = 0;
  int cyc         = 0;
  int last_accept = 0;
  int t0          = 0;

  logic [15:0] exp_q[$];

  format9_madd_accum dut (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_data   (sum_data)
`ifdef FORMAT9_ACC_FLAGS_EN
    ,
    .sum_flags  (sum_flags)
`endif
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers (called on a negedge) ----------------
  task automatic send_prod(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = last;
    while (prod_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (prod_ready !== 1'b1) check_eq("prod_accept_timeout", {31'd0, prod_ready}, 32'd1);
    last_accept = cyc;
    @(negedge clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic collect_sum(input string tag);
    int          n;
    logic [15:0] exp_v;
    n         = 0;
    sum_ready = 1'b1;
    while (sum_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    check_eq({tag, "_valid"}, {31'd0, sum_valid}, 32'd1);
    check_eq(tag, {16'd0, sum_data}, {16'd0, exp_v});
`ifdef FORMAT9_ACC_FLAGS_EN
    seen_flags = sum_flags;
`endif
    @(negedge clk);
    sum_ready = 1'b0;
  endtask

  task automatic vec2(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] e, input string tag);
    exp_q.push_back(e);
    send_prod(a, 1'b0);
    send_prod(b, 1'b1);
    collect_sum(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst        = 1'b1;
    prod_valid = 1'b0;
    prod_data  = 16'h0000;
    prod_last  = 1'b0;
    sum_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_prod_ready", {31'd0, prod_ready}, 32'd0);
    check_eq("rst_sum_valid",  {31'd0, sum_valid},  32'd0);
    check_eq("rst_sum_data",   {16'd0, sum_data},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", {31'd0, prod_ready}, 32'd1);

    // Basic sum plus acceptance spacing.
    exp_q.push_back(16'h4000);
    send_prod(16'h3F80, 1'b0);
    t0 = last_accept;
    check_eq("ready_low_in_align", {31'd0, prod_ready}, 32'd0);
    send_prod(16'h3F80, 1'b1);
    check_eq("accept_spacing", last_accept - t0, 32'd4);
    collect_sum("one_plus_one");
`ifdef FORMAT9_ACC_FLAGS_EN
    check_eq("flags_clean", {29'd0, seen_flags}, 32'd0);
`endif

    vec2(16'h3F80, 16'h4000, 16'h4040, "one_plus_two");
    vec2(16'h3F80, 16'hBF80, 16'h0000, "cancel");
    vec2(16'h3F80, 16'h3B80, 16'h3F80, "tie_even");

    exp_q.push_back(16'h3F81);
    send_prod(16'h3F80, 1'b0);
    send_prod(16'h3B80, 1'b0);
    send_prod(16'h3B80, 1'b1);
    collect_sum("guard_kept");

    vec2(16'h4040, 16'hBF80, 16'h4000, "sub_shift");
    vec2(16'h3FFF, 16'h3B80, 16'h4000, "round_carry");
    vec2(16'h0000, 16'h4000, 16'h4000, "zero_operand");

    exp_q.push_back(16'hC0A0);
    send_prod(16'hC0A0, 1'b1);
    collect_sum("single");

    vec2(16'h7FC0, 16'h3F80, 16'h7FC0, "nan_in");
`ifdef FORMAT9_ACC_FLAGS_EN
    check_eq("flags_nan", {29'd0, seen_flags}, 32'd4);
`endif
    vec2(16'h7F80, 16'hFF80, 16'h7FC0, "inf_minus_inf");
`ifdef FORMAT9_ACC_FLAGS_EN
    check_eq("flags_inf_clash", {29'd0, seen_flags}, 32'd4);
`endif
    vec2(16'h7F80, 16'h4000, 16'h7F80, "inf_plus_fin");
`ifdef FORMAT9_ACC_FLAGS_EN
    check_eq("flags_inf_in", {29'd0, seen_flags}, 32'd0);
`endif
    vec2(16'h7F00, 16'h7F00, 16'h7F80, "overflow");
`ifdef FORMAT9_ACC_FLAGS_EN
    check_eq("flags_overflow", {29'd0, seen_flags}, 32'd2);
`endif
    vec2(16'h00C0, 16'h8080, 16'h0000, "underflow");
`ifdef FORMAT9_ACC_FLAGS_EN
    check_eq("flags_underflow", {29'd0, seen_flags}, 32'd1);
`endif

    // Backpressure: sum held, products refused, then a fresh vector.
    send_prod(16'h3F80, 1'b0);
    send_prod(16'h3F80, 1'b1);
    n = 0;
    while (sum_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    prod_valid = 1'b1;
    prod_data  = 16'h4000;
    prod_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_sum_valid",  {31'd0, sum_valid},  32'd1);
      check_eq("bp_sum_data",   {16'd0, sum_data},   32'h4000);
      check_eq("bp_prod_ready", {31'd0, prod_ready}, 32'd0);
      @(negedge clk);
    end
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    check_eq("bp_accept_next", {31'd0, prod_ready}, 32'd1);
    @(negedge clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    exp_q.push_back(16'h4000);
    collect_sum("bp_fresh_vector");

    // Reset during ADD of the second product.
    send_prod(16'h3F80, 1'b0);
    send_prod(16'h3F80, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_prod_ready", {31'd0, prod_ready}, 32'd0);
    check_eq("midrst_sum_valid",  {31'd0, sum_valid},  32'd0);
    check_eq("midrst_sum_data",   {16'd0, sum_data},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(16'h4000);
    send_prod(16'h4000, 1'b1);
    collect_sum("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/format9_madd_accum.md
Name: format9_madd_accum

Overview:
- Downstream stage of the format9 MADD multiplier.
- Consumes the 16-bit products (1 sign / 8 exp / 7 mantissa, bias 127) over a valid/ready stream and accumulates one vector into an extended-precision internal sum.
- On the product flagged last, rounds the sum to the same 16-bit format and presents it on an output valid/ready stream.
- Multi-cycle FSM adder, one product in flight.

Parameters:
- GUARD_BITS, 3: extra mantissa bits kept below the 7-bit fraction in the accumulator; the LSB acts as sticky.
- EXP_BIAS, 127: exponent bias of the product and sum format.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- prod_valid  input  1  product available.
- prod_ready  output  1  block accepts the product this cycle.
- prod_data  input  16  product {S, E[7:0], M[6:0]}.
- prod_last  input  1  final product of the vector; sampled with prod_data.
- sum_valid  output  1  rounded sum available.
- sum_ready  input  1  consumer accepts the sum.
- sum_data  output  16  rounded vector sum, same format.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: prod_ready=0, sum_valid=0, sum_data=0. FSM in IDLE. Accumulator = +0 with no NaN/inf flags. prod_ready rises the first clk edge after rst deasserts.
- Reset mid-operation: an in-flight product or pending sum is discarded and the accumulator is cleared.
- States:
  - IDLE: prod_ready=1. Handshake = prod_valid & prod_ready. It latches the operand and prod_last, then moves to ALIGN.
  - ALIGN: compares exponents and right-shifts the smaller-exponent significand by the difference. Bits shifted out OR into the sticky bit. A difference ≥ 8+GUARD_BITS leaves sticky only.
  - ADD: signed-magnitude add or subtract. The result sign follows the larger magnitude.
  - NORM: leading-one detect on the magnitude, then shift. Exponent is adjusted ±.
    - Goes to OUT if last is latched, else to IDLE.
  - OUT: sum_valid=1, prod_ready=0. Stays until sum_ready. On handshake: clear accumulator, sum_valid→0, go to IDLE.
- Latency and throughput:
  - Fixed 3 cycles per product (ALIGN, ADD, NORM), so one product is accepted per 4 cycles.
  - sum_valid asserts the cycle after NORM of the last product.
  - sum_data is held stable while sum_valid & !sum_ready.
- Input decoding (no subnormals):
  - E=0 → zero, regardless of M.
  - E=255 with M=0 → ±inf.
  - E=255 with M≠0 → NaN.
  - Zero products still take the full 3 cycles.
- Special values:
  - A NaN operand, or inf + opposite inf, sets a sticky NaN state. Output is then 16'h7FC0.
  - inf + finite → inf; the inf state is sticky.
  - Exact cancellation → +0.
  - Normalised exponent ≥255 → ±inf (sticky).
  - Normalised exponent ≤0 → flush to +0.
- Rounding:
  - No rounding between products; guard bits are kept in the accumulator.
  - Round-to-nearest-even when packing in OUT.
  - Mantissa carry-out increments the exponent; reaching 255 gives ±inf.
- Single-product vector: output equals that product, passed through the same rounding.
- A vector always contains at least one product.
- prod_valid in OUT is ignored (prod_ready=0).

Optional Feature:
- Macro FORMAT9_ACC_FLAGS_EN.
- When defined, adds output port sum_flags [2:0] = {invalid, overflow, underflow}.
  - invalid: NaN input or inf−inf.
  - overflow: inf produced by arithmetic, not by an inf input.
  - underflow: a flush to zero occurred.
  - Sticky per vector, valid with sum_valid, cleared on the sum handshake and on rst.
- When undefined: the port and flag logic are absent; all other behaviour is identical.

Decomposition:
- Package format9_pkg holds:
  - constants QNAN=16'h7FC0, EXP_INF=8'hFF, EXP_BIAS;
  - the state enum {IDLE, ALIGN, ADD, NORM, OUT};
  - the accumulator struct {sign, exp[9:0] signed, mant[8+GUARD_BITS-1:0], is_nan, is_inf}.
- Sub-module format9_lzc: combinational leading-zero counter over the accumulator magnitude, instantiated in NORM.

Test Plan:
- Basic: 0x3F80, 0x3F80(last) → sum_data=0x4000. Then 0x3F80, 0x4000(last) → 0x4040. prod_ready pulses once every 4 cycles.
- Cancellation and guard bits:
  - 0x3F80, 0xBF80(last) → 0x0000.
  - 0x3F80, 0x3B80(last) → 0x3F80 (tie, rounds to even).
  - 0x3F80, 0x3B80, 0x3B80(last) → 0x3F81 (no intermediate rounding).
- Specials:
  - 0x7FC0, 0x3F80(last) → 0x7FC0.
  - 0x7F80, 0xFF80(last) → 0x7FC0.
  - 0x7F80, 0x4000(last) → 0x7F80.
  - 0x7F00, 0x7F00(last) → 0x7F80; with FORMAT9_ACC_FLAGS_EN, sum_flags=3'b010.
- Backpressure: hold sum_ready=0 for 5 cycles with prod_valid=1 → sum_data stable, prod_ready=0 throughout. The next vector is accepted the cycle after the sum handshake and starts from +0.
- Reset mid-operation: assert rst during ADD of the 2nd product → outputs reset immediately. A following vector 0x4000(last) → 0x4000.
